// File: rtl/freq_measure_ctrl.sv
// freq_measure_ctrl: sequences one frequency-meter measurement per start request.
//   Clears the meter for RST_CYCLES clocks, waits for meter_ready, reads the eight
//   result bytes (3 clocks per byte), then publishes count_f/count_ref atomically.
//
// Optional feature: define FREQ_MEASURE_CTRL_TIMEOUT_EN to bound the wait for
//   meter_ready to TIMEOUT_CYCLES clocks. When it expires the run ends with
//   timeout=1 and valid=0. Without the macro the wait is unbounded and timeout is 0.
//
// Ports:
//   clk, reset         - rising-edge clock, asynchronous active-low reset
//   start              - one-cycle request, accepted only while idle
//   busy, done         - run in progress / one-cycle end-of-run pulse
//   valid, timeout     - result status of the last run
//   count_f, count_ref - measured and reference counts (meter bytes 0..3 / 4..7)
//   meter_*            - frequency meter clear, ready, read strobe, byte select, data
module freq_measure_ctrl #(
  parameter int unsigned RST_CYCLES     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 200000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        valid,
  output logic        timeout,
  output logic [31:0] count_f,
  output logic [31:0] count_ref,
  output logic        meter_reset_n,
  input  logic        meter_ready,
  output logic        meter_rd,
  output logic [2:0]  meter_address,
  input  logic [7:0]  meter_data
);

  if (RST_CYCLES < 1 || RST_CYCLES > 255) begin : gen_bad_rst_cycles
    $error("RST_CYCLES must be in 1..255");
  end
  if (TIMEOUT_CYCLES < 1) begin : gen_bad_timeout_cycles
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StWaitReady,
    StRdSetup,
    StRdStrobe,
    StRdCapture,
    StFinish
  } state_e;

  localparam logic [7:0] RstLast = 8'(RST_CYCLES - 1);

  state_e      state_q, state_d;
  logic [2:0]  index_q, index_d;
  logic [7:0]  clr_cnt_q, clr_cnt_d;
  logic [63:0] staging_q, staging_d;
  logic [31:0] count_f_q, count_f_d;
  logic [31:0] count_ref_q, count_ref_d;
  logic        valid_q, valid_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        meter_rd_q, meter_rd_d;
  logic        meter_reset_n_q, meter_reset_n_d;

`ifdef FREQ_MEASURE_CTRL_TIMEOUT_EN
  localparam logic [31:0] TmoLast = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] tmo_cnt_q, tmo_cnt_d;
  logic        timeout_q, timeout_d;
`endif

  always_comb begin
    state_d     = state_q;
    index_d     = index_q;
    clr_cnt_d   = clr_cnt_q;
    staging_d   = staging_q;
    count_f_d   = count_f_q;
    count_ref_d = count_ref_q;
    valid_d     = valid_q;
`ifdef FREQ_MEASURE_CTRL_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt_q;
    timeout_d   = timeout_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StClear;
          valid_d   = 1'b0;
          index_d   = 3'd0;
          clr_cnt_d = 8'd0;
`ifdef FREQ_MEASURE_CTRL_TIMEOUT_EN
          timeout_d = 1'b0;
`endif
        end
      end
      StClear: begin
        if (clr_cnt_q == RstLast) begin
          state_d = StWaitReady;
`ifdef FREQ_MEASURE_CTRL_TIMEOUT_EN
          tmo_cnt_d = 32'd0;
`endif
        end else begin
          clr_cnt_d = clr_cnt_q + 8'd1;
        end
      end
      StWaitReady: begin
        // meter_ready is tested first so it wins over a simultaneous expiry.
        if (meter_ready) begin
          state_d = StRdSetup;
`ifdef FREQ_MEASURE_CTRL_TIMEOUT_EN
        end else if (tmo_cnt_q == TmoLast) begin
          state_d   = StFinish;
          timeout_d = 1'b1;
          valid_d   = 1'b0;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 32'd1;
`endif
        end
      end
      StRdSetup:  state_d = StRdStrobe;
      StRdStrobe: state_d = StRdCapture;
      StRdCapture: begin
        staging_d[{index_q, 3'b000} +: 8] = meter_data;
        if (index_q == 3'd7) begin
          state_d     = StFinish;
          valid_d     = 1'b1;
          // Load from the merged staging value so the counts appear with done.
          count_f_d   = staging_d[31:0];
          count_ref_d = staging_d[63:32];
        end else begin
          index_d = index_q + 3'd1;
          state_d = StRdSetup;
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase

    // Outputs are registered from the next state so they line up with state_q.
    busy_d          = (state_d != StIdle);
    done_d          = (state_d == StFinish);
    meter_rd_d      = !(state_d inside {StRdStrobe, StRdCapture});
    meter_reset_n_d = !(state_d inside {StIdle, StClear});
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= StIdle;
      index_q         <= 3'd0;
      clr_cnt_q       <= 8'd0;
      staging_q       <= 64'd0;
      count_f_q       <= 32'd0;
      count_ref_q     <= 32'd0;
      valid_q         <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      meter_rd_q      <= 1'b1;
      meter_reset_n_q <= 1'b0;
`ifdef FREQ_MEASURE_CTRL_TIMEOUT_EN
      tmo_cnt_q       <= 32'd0;
      timeout_q       <= 1'b0;
`endif
    end else begin
      state_q         <= state_d;
      index_q         <= index_d;
      clr_cnt_q       <= clr_cnt_d;
      staging_q       <= staging_d;
      count_f_q       <= count_f_d;
      count_ref_q     <= count_ref_d;
      valid_q         <= valid_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      meter_rd_q      <= meter_rd_d;
      meter_reset_n_q <= meter_reset_n_d;
`ifdef FREQ_MEASURE_CTRL_TIMEOUT_EN
      tmo_cnt_q       <= tmo_cnt_d;
      timeout_q       <= timeout_d;
`endif
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign valid         = valid_q;
  assign count_f       = count_f_q;
  assign count_ref     = count_ref_q;
  assign meter_rd      = meter_rd_q;
  assign meter_reset_n = meter_reset_n_q;
  // The byte index only moves while meter_rd is high, so it can drive the address.
  assign meter_address = index_q;

`ifdef FREQ_MEASURE_CTRL_TIMEOUT_EN
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_freq_measure_ctrl.sv
module tb_freq_measure_ctrl;

  localparam int unsigned RstCycles = 4;
`ifdef FREQ_MEASURE_CTRL_TIMEOUT_EN
  localparam int unsigned TimeoutCycles = 50;
  localparam int unsigned LongDelay     = 49;
`else
  localparam int unsigned TimeoutCycles = 200000000;
  localparam int unsigned LongDelay     = 1000;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        busy, done, valid, timeout;
  logic [31:0] count_f, count_ref;
  logic        meter_reset_n, meter_ready, meter_rd;
  logic [2:0]  meter_address;
  logic [7:0]  meter_data = 8'h00;

  always #5 clk = ~clk;

  freq_measure_ctrl #(
    .RST_CYCLES    (RstCycles),
    .TIMEOUT_CYCLES(TimeoutCycles)
  ) u_dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .valid        (valid),
    .timeout      (timeout),
    .count_f      (count_f),
    .count_ref    (count_ref),
    .meter_reset_n(meter_reset_n),
    .meter_ready  (meter_ready),
    .meter_rd     (meter_rd),
    .meter_address(meter_address),
    .meter_data   (meter_data)
  );

  // Meter model: counts clocks since its clear was released, raises ready after
  // ready_delay clocks, and latches the addressed byte on the falling read strobe.
  logic [31:0] meter_a, meter_b;
  int unsigned ready_delay;
  bit          ready_en;
  int unsigned mcnt = 0;

  always @(posedge clk) begin
    if (!meter_reset_n) mcnt <= 0;
    else if (mcnt < 100000) mcnt <= mcnt + 1;
  end

  assign meter_ready = ready_en && meter_reset_n && (mcnt >= ready_delay);

  always @(negedge meter_rd) begin
    logic [63:0] words;
    words = {meter_b, meter_a};
    meter_data <= words[{meter_address, 3'b000} +: 8];
  end

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Address must not move while the read strobe is low.
  logic       prev_rd = 1'b1;
  logic [2:0] prev_addr = 3'd0;
  always @(negedge clk) begin
    if (reset === 1'b1 && prev_rd === 1'b0 && meter_rd === 1'b0)
      check("addr_stable", 64'(meter_address), 64'(prev_addr));
    prev_rd   <= meter_rd;
    prev_addr <= meter_address;
  end

  // Reference state: what count/valid/timeout must show right now.
  logic [31:0] exp_cf = 32'd0;
  logic [31:0] exp_cr = 32'd0;
  logic        exp_valid = 1'b0;
  logic        exp_to = 1'b0;

  function automatic logic [63:0] ctl_vec();
    return 64'({busy, done, valid, timeout, meter_reset_n, meter_rd});
  endfunction

  // One measurement seen cycle by cycle. k counts clocks after the start edge.
  // Timeline: k=1..RstCycles clear, then wait, 24 read cycles, one finish cycle.
  // abort_k != 0 asserts reset during cycle abort_k and ends the run there.
  task automatic run_measurement(input logic [31:0] a, input logic [31:0] b,
                                 input int unsigned delay, input bit ready_on,
                                 input bit spam, input int unsigned abort_k);
    int unsigned final_k, rd_first, j;
    bit          to_run, in_rd;
    logic [5:0]  e_ctl;
    meter_a     = a;
    meter_b     = b;
    ready_delay = delay;
    ready_en    = ready_on;
    to_run      = !ready_on;
    rd_first    = RstCycles + delay + 2;
    final_k     = to_run ? RstCycles + 1 + TimeoutCycles : rd_first + 24;
    start = 1'b1;
    @(posedge clk); #1;
    for (int unsigned k = 1; k <= final_k + 2; k++) begin
      if (k == 1) begin
        exp_valid = 1'b0;
        exp_to    = 1'b0;
      end
      if (k == final_k) begin
        if (to_run) exp_to = 1'b1;
        else begin
          exp_cf    = a;
          exp_cr    = b;
          exp_valid = 1'b1;
        end
      end
      in_rd = !to_run && k >= rd_first && k < rd_first + 24;
      j     = k - rd_first;
      e_ctl = {k <= final_k, k == final_k, exp_valid, exp_to,
               k > RstCycles && k <= final_k, !(in_rd && (j % 3 != 0))};
      check("ctl", ctl_vec(), 64'(e_ctl));
      check("counts", {count_ref, count_f}, {exp_cr, exp_cf});
      if (in_rd) check("addr", 64'(meter_address), 64'(j / 3));
      if (k == abort_k) begin
        reset = 1'b0;
        start = 1'b0;
        #1;
        exp_cf    = 32'd0;
        exp_cr    = 32'd0;
        exp_valid = 1'b0;
        exp_to    = 1'b0;
        check("abort_ctl", ctl_vec(), 64'(6'b000001));
        check("abort_addr", 64'(meter_address), 64'd0);
        check("abort_counts", {count_ref, count_f}, 64'd0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
        repeat (4) begin
          @(posedge clk); #1;
          check("post_abort_ctl", ctl_vec(), 64'(6'b000001));
        end
        return;
      end
      // Start spam covers the busy window and the finish cycle, never idle.
      if (spam && k <= final_k) start = (k == final_k) ? 1'b1 : 1'($urandom & 1);
      else start = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int unsigned d;
    reset       = 1'b0;
    start       = 1'b0;
    ready_en    = 1'b0;
    ready_delay = 0;
    meter_a     = 32'd0;
    meter_b     = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ctl", ctl_vec(), 64'(6'b000001));
    check("rst_addr", 64'(meter_address), 64'd0);
    check("rst_counts", {count_ref, count_f}, 64'd0);
    reset = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      check("idle_ctl", ctl_vec(), 64'(6'b000001));
    end

    run_measurement(32'h12345678, 32'h9ABCDEF0, LongDelay, 1'b1, 1'b0, 0);
    run_measurement($urandom, $urandom, 0, 1'b1, 1'b1, 0);
    for (int i = 0; i < 4; i++)
      run_measurement($urandom, $urandom, $urandom_range(0, 30), 1'b1,
                      1'($urandom_range(0, 1)), 0);
`ifdef FREQ_MEASURE_CTRL_TIMEOUT_EN
    run_measurement($urandom, $urandom, 0, 1'b0, 1'b0, 0);
    run_measurement($urandom, $urandom, 0, 1'b0, 1'b1, 0);
    run_measurement($urandom, $urandom, TimeoutCycles - 1, 1'b1, 1'b1, 0);
`endif
    d = $urandom_range(0, 20);
    run_measurement($urandom, $urandom, d, 1'b1, 1'b0, RstCycles + d + 2 + 16);
    run_measurement($urandom, $urandom, $urandom_range(0, 20), 1'b1, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
